gmm_ram_mover: RTL and testbench
================================

# gmm_ram_mover

Avalon-MM master that drives the second port (s2) of the 64 x 256-bit GMM parameter RAM on behalf of the per-pixel model-update pipeline. On a start command it sweeps a contiguous block of RAM words: each word is read, handed to the update pipeline on a valid/ready stream, and the updated word returned on a second stream is written back to the same address. It is the initiator for the RAM's responder port, so the pipeline never sees raw Avalon timing.

## Interface
Parameters:
- DATA_W, 256, RAM word width; must equal the RAM port width.
- ADDR_W, 6, RAM word address width (64 words).
- READ_LATENCY, 1, cycles from read command to valid m_readdata; legal range 1..3.

Ports:
- clk  in  1  single clock shared with the RAM.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle command pulse; honoured only when busy=0.
- base_addr  in  ADDR_W  first word address, sampled on start.
- word_count  in  ADDR_W+1  number of words, 0..64, sampled on start.
- busy  out  1  high from the cycle after accepted start until done.
- done  out  1  one-cycle pulse when the sweep completes.
- out_data  out  DATA_W  word read from RAM.
- out_valid  out  1  out_data valid.
- out_ready  in  1  pipeline accepts out_data.
- in_data  in  DATA_W  updated word from pipeline.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block accepts in_data.
- m_address  out  ADDR_W  RAM s2 address.
- m_chipselect  out  1  RAM s2 chipselect.
- m_write  out  1  RAM s2 write.
- m_writedata  out  DATA_W  RAM s2 write data.
- m_byteenable  out  DATA_W/8  constant all-ones.
- m_clken  out  1  constant 1.
- m_readdata  in  DATA_W  RAM s2 read data.

## Operation
- States: IDLE, READ, RD_WAIT, OUT, IN, WRITE, DONE.
- IDLE: start=1 with word_count>0 → latch base_addr into addr register, word_count into remaining counter, go READ. start with word_count=0 → go DONE directly, no bus activity. start while busy=1 is ignored.
- READ (1 cycle): m_chipselect=1, m_write=0, m_address=addr → RD_WAIT.
- RD_WAIT: counts READ_LATENCY cycles; in the last one captures m_readdata into the out register → OUT.
- OUT: out_valid=1, out_data stable until out_ready=1; on handshake → IN.
- IN: in_ready=1; on in_valid=1 capture in_data into the write register → WRITE.
- WRITE (1 cycle): m_chipselect=1, m_write=1, m_address=addr, m_writedata=write register. Decrement remaining; increment addr modulo 2^ADDR_W (63 wraps to 0). remaining becomes 0 → DONE, else → READ.
- DONE (1 cycle): done=1 → IDLE.
- in_valid outside IN is ignored (in_ready=0); out_ready outside OUT is ignored.
- out_valid and in_ready are never high in the same cycle.

## Timing
- Reset values: busy=0, done=0, out_valid=0, in_ready=0, m_chipselect=0, m_write=0, m_address=0, m_writedata=0, out_data=0; state IDLE.
- All outputs registered or decoded from the state register only; no combinational path from out_ready/in_valid to any output.
- With READ_LATENCY=1, start accepted at edge 0: READ cycle 1, RD_WAIT cycle 2, out_valid from cycle 3.
- Per word with zero-wait pipeline (out_ready and in_valid held high): READ, RD_WAIT×READ_LATENCY, OUT, IN, WRITE = 4+READ_LATENCY cycles; 64 words at latency 1 = 320 cycles plus DONE.
- Write-back of word N completes before read of word N+1 is issued, so a sweep covering the whole RAM with wrap never reads stale data.
- Reset mid-sweep: next cycle all outputs at reset values, no partial write issued; captured words discarded.

## Structure
- Package gmm_ram_pkg: DATA_W/ADDR_W defaults, byteenable width derivation, state enum type. Shared with the RAM wrapper and the update pipeline.
- Single module; no sub-module is natural (datapath is two word registers plus counters).

## Test plan
- Single word: base=5, count=1, RAM[5]=0xA5..A5, pipeline returns ~data → one read at 5, out_data=0xA5..A5, one write of 0x5A..5A at 5, done 1 cycle after write, RAM[5]=0x5A..5A.
- Wrap: base=62, count=4 → read/write address order 62,63,0,1; busy high throughout; done once.
- Backpressure: out_ready low 10 cycles, in_valid delayed 7 cycles → out_data stable, no bus activity during stalls, final RAM contents correct.
- count=0 and start while busy: count=0 → done pulse next cycle, m_chipselect never high; second start mid-sweep → ignored, sweep length unchanged.
- Reset mid-sweep: assert reset in IN state of word 3 of 8 → word 3 not written, all outputs at reset values next cycle, new start then runs cleanly.
- Full sweep, READ_LATENCY=2, base=0, count=64, pipeline adds 1 to each word → all 64 words incremented, 6 cycles per word, done at expected cycle.

Source files
------------

// File: rtl/gmm_ram_pkg.sv
// Shared definitions for the GMM parameter RAM: default geometry, byteenable
// width derivation and the RAM mover's state and control-flag types.
package gmm_ram_pkg;

    localparam int DEFAULT_DATA_W = 256;
    localparam int DEFAULT_ADDR_W = 6;

    function automatic int be_width(input int data_w);
        return data_w / 8;
    endfunction

    typedef enum logic [2:0] {
        IDLE,
        READ,
        RD_WAIT,
        OUT,
        IN,
        WRITE,
        DONE
    } mover_state_t;

    typedef struct packed {
        logic busy;
        logic done;
        logic out_valid;
        logic in_ready;
        logic chipselect;
        logic write;
    } mover_ctrl_t;

    // Control flags that must be visible while the mover sits in a given state.
    function automatic mover_ctrl_t state_ctrl(input mover_state_t s);
        mover_ctrl_t c;
        c            = '0;
        c.busy       = (s != IDLE);
        c.done       = (s == DONE);
        c.out_valid  = (s == OUT);
        c.in_ready   = (s == IN);
        c.chipselect = (s == READ) || (s == WRITE);
        c.write      = (s == WRITE);
        return c;
    endfunction

endpackage

// File: rtl/gmm_ram_mover.sv
// Avalon-MM master for port s2 of the GMM parameter RAM: reads a block of words,
// streams each through the update pipeline and writes the result back in place.
module gmm_ram_mover
    import gmm_ram_pkg::*;
#(
    parameter int DATA_W       = DEFAULT_DATA_W,
    parameter int ADDR_W       = DEFAULT_ADDR_W,
    parameter int READ_LATENCY = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [ADDR_W-1:0]             base_addr,
    input  logic [ADDR_W:0]               word_count,
    output logic                          busy,
    output logic                          done,
    output logic [DATA_W-1:0]             out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    input  logic [DATA_W-1:0]             in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [ADDR_W-1:0]             m_address,
    output logic                          m_chipselect,
    output logic                          m_write,
    output logic [DATA_W-1:0]             m_writedata,
    output logic [be_width(DATA_W)-1:0]   m_byteenable,
    output logic                          m_clken,
    input  logic [DATA_W-1:0]             m_readdata
);

    localparam int LAT_W = 2;

    mover_state_t      state;
    mover_state_t      state_next;
    mover_ctrl_t       ctrl;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   remaining;
    logic [LAT_W-1:0]  lat_cnt;
    logic              lat_done;
    logic [DATA_W-1:0] out_reg;
    logic [DATA_W-1:0] wr_reg;

    assign lat_done = (lat_cnt == LAT_W'(READ_LATENCY - 1));

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = (word_count != '0) ? READ : DONE;
            READ:    state_next = RD_WAIT;
            RD_WAIT: if (lat_done) state_next = OUT;
            OUT:     if (out_ready) state_next = IN;
            IN:      if (in_valid) state_next = WRITE;
            WRITE:   state_next = (remaining == (ADDR_W+1)'(1)) ? DONE : READ;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Control flags are registered from the next state so every output comes
    // straight off a flop; the address wraps naturally at 2^ADDR_W.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ctrl      <= '0;
            addr      <= '0;
            remaining <= '0;
            lat_cnt   <= '0;
            out_reg   <= '0;
            wr_reg    <= '0;
        end else begin
            state <= state_next;
            ctrl  <= state_ctrl(state_next);
            case (state)
                IDLE: begin
                    if (start && word_count != '0) begin
                        addr      <= base_addr;
                        remaining <= word_count;
                    end
                end
                READ: lat_cnt <= '0;
                RD_WAIT: begin
                    if (lat_done) out_reg <= m_readdata;
                    else          lat_cnt <= lat_cnt + 1'b1;
                end
                IN: if (in_valid) wr_reg <= in_data;
                WRITE: begin
                    remaining <= remaining - 1'b1;
                    addr      <= addr + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy         = ctrl.busy;
    assign done         = ctrl.done;
    assign out_valid    = ctrl.out_valid;
    assign in_ready     = ctrl.in_ready;
    assign m_chipselect = ctrl.chipselect;
    assign m_write      = ctrl.write;
    assign m_address    = addr;
    assign m_writedata  = wr_reg;
    assign out_data     = out_reg;
    assign m_byteenable = '1;
    assign m_clken      = 1'b1;

endmodule

// File: tb/tb_gmm_ram_mover.sv
// Scoreboard bench for gmm_ram_mover: a behavioural RAM with read latency 2 and
// a configurable update pipeline; expected bus traffic is queued at start.
module tb_gmm_ram_mover;

    localparam int LAT = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [5:0]   base_addr;
    logic [6:0]   word_count;
    logic         busy, done;
    logic [255:0] out_data;
    logic         out_valid, out_ready;
    logic [255:0] in_data;
    logic         in_valid, in_ready;
    logic [5:0]   m_address;
    logic         m_chipselect, m_write;
    logic [255:0] m_writedata;
    logic [31:0]  m_byteenable;
    logic         m_clken;
    logic [255:0] m_readdata;

    logic         load_en;
    logic [5:0]   load_addr;
    logic [255:0] load_data;
    logic [255:0] mem [64];
    logic [255:0] rd_pipe [LAT];
    logic [255:0] exp_img [64];

    int           exp_rd_q [$];
    int           exp_wa_q [$];
    logic [255:0] exp_wd_q [$];
    logic [255:0] exp_out_q [$];

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    gmm_ram_mover #(.DATA_W(256), .ADDR_W(6), .READ_LATENCY(LAT)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .word_count(word_count), .busy(busy), .done(done),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .m_address(m_address), .m_chipselect(m_chipselect), .m_write(m_write),
        .m_writedata(m_writedata), .m_byteenable(m_byteenable),
        .m_clken(m_clken), .m_readdata(m_readdata)
    );

    // RAM model: registered read pipeline of depth LAT, write on chipselect+write.
    always @(posedge clk) begin
        if (load_en) mem[load_addr] <= load_data;
        else if (m_chipselect && m_write) mem[m_address] <= m_writedata;
        rd_pipe[0] <= mem[m_address];
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign m_readdata = rd_pipe[LAT-1];

    function automatic logic [255:0] xform(input int op, input logic [255:0] d);
        return (op == 0) ? ~d : d + 256'd1;
    endfunction

    task automatic load_word(input int a, input logic [255:0] d);
        load_en   = 1'b1;
        load_addr = a[5:0];
        load_data = d;
        exp_img[a] = d;
        @(negedge clk);
        load_en   = 1'b0;
    endtask

    // Runs one sweep acting as the update pipeline; optionally stops at the IN
    // state of word abort_word (zero-based) leaving in_valid asserted.
    task automatic drive_sweep(input int base, input int count, input int op,
                               input int stall_out, input int stall_in,
                               input bit noise, input int mid_start_cyc,
                               input int abort_word, input int exp_done_cyc,
                               output bit aborted);
        logic [255:0] work [64];
        logic [255:0] cur_exp, pending, expd;
        int a, expa, ov_cnt, iv_cnt, words_in, first_ov, done_cyc, bad;
        aborted = 1'b0; ov_cnt = 0; iv_cnt = 0; words_in = 0;
        first_ov = -1; done_cyc = -1; pending = '0; cur_exp = '0;
        for (int i = 0; i < 64; i++) work[i] = exp_img[i];
        exp_rd_q.delete(); exp_wa_q.delete(); exp_wd_q.delete(); exp_out_q.delete();
        for (int i = 0; i < count; i++) begin
            a = (base + i) % 64;
            exp_rd_q.push_back(a);
            exp_out_q.push_back(work[a]);
            work[a] = xform(op, work[a]);
            exp_wa_q.push_back(a);
            exp_wd_q.push_back(work[a]);
        end
        base_addr  = base[5:0];
        word_count = count[6:0];
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc <= 2000 && done_cyc < 0 && !aborted; cyc++) begin
            vectors++;
            if (out_valid === 1'b1 && in_ready === 1'b1) begin
                miscompares++;
                $display("[TB] FAIL excl cyc %0d: out_valid=%b in_ready=%b, required not both", cyc, out_valid, in_ready);
            end
            vectors++;
            if (busy !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL busy cyc %0d: got %b expected 1", cyc, busy);
            end
            if (m_chipselect === 1'b1) begin
                vectors++;
                if (m_write === 1'b0) begin
                    if (exp_rd_q.size() == 0) begin
                        miscompares++;
                        $display("[TB] FAIL unexpected_read cyc %0d: addr %0d, required no read", cyc, m_address);
                    end else begin
                        expa = exp_rd_q.pop_front();
                        if (m_address !== expa[5:0]) begin
                            miscompares++;
                            $display("[TB] FAIL rd_addr cyc %0d: got %0d expected %0d", cyc, m_address, expa);
                        end
                    end
                end else begin
                    if (exp_wa_q.size() == 0) begin
                        miscompares++;
                        $display("[TB] FAIL unexpected_write cyc %0d: addr %0d, required no write", cyc, m_address);
                    end else begin
                        expa = exp_wa_q.pop_front();
                        expd = exp_wd_q.pop_front();
                        exp_img[expa] = expd;
                        if (m_address !== expa[5:0] || m_writedata !== expd) begin
                            miscompares++;
                            $display("[TB] FAIL wr cyc %0d: got @%0d %h expected @%0d %h", cyc, m_address, m_writedata, expa, expd);
                        end
                    end
                end
            end
            if (done === 1'b1) done_cyc = cyc;
            if (out_valid === 1'b1) begin
                if (first_ov < 0) first_ov = cyc;
                if (ov_cnt == 0) begin
                    if (exp_out_q.size() == 0) begin
                        miscompares++;
                        $display("[TB] FAIL unexpected_out cyc %0d: out_valid=1, required 0", cyc);
                    end else cur_exp = exp_out_q.pop_front();
                end
                vectors++;
                if (out_data !== cur_exp) begin
                    miscompares++;
                    $display("[TB] FAIL out_data cyc %0d: got %h expected %h", cyc, out_data, cur_exp);
                end
                if (ov_cnt >= stall_out) begin
                    out_ready = 1'b1;
                    pending   = xform(op, out_data);
                end else out_ready = 1'b0;
                ov_cnt++;
            end else begin
                ov_cnt    = 0;
                out_ready = noise & cyc[0];
            end
            if (in_ready === 1'b1) begin
                if (iv_cnt == 0) words_in++;
                if (abort_word >= 0 && words_in == abort_word + 1) begin
                    aborted  = 1'b1;
                    in_valid = 1'b1;
                    in_data  = pending;
                end else if (iv_cnt >= stall_in) begin
                    in_valid = 1'b1;
                    in_data  = pending;
                end else begin
                    in_valid = 1'b0;
                    in_data  = ~pending;
                end
                iv_cnt++;
            end else begin
                iv_cnt   = 0;
                in_valid = noise;
                in_data  = ~pending;
            end
            start = (cyc == mid_start_cyc);
            if (start) begin
                base_addr  = 6'd33;
                word_count = 7'd5;
            end
            if (done_cyc < 0 && !aborted) @(negedge clk);
        end
        start = 1'b0;
        out_ready = 1'b0;
        if (!aborted) begin
            in_valid = 1'b0;
            vectors++;
            if (done_cyc < 0) begin
                miscompares++;
                $display("[TB] FAIL timeout: no done within 2000 cycles, required done");
            end
            if (exp_done_cyc > 0) begin
                vectors++;
                if (done_cyc != exp_done_cyc) begin
                    miscompares++;
                    $display("[TB] FAIL done_cycle: got %0d expected %0d", done_cyc, exp_done_cyc);
                end
            end
            if (count > 0) begin
                vectors++;
                if (first_ov != 2 + LAT) begin
                    miscompares++;
                    $display("[TB] FAIL first_out_valid: got cycle %0d expected %0d", first_ov, 2 + LAT);
                end
            end
            vectors++;
            if (exp_rd_q.size() + exp_wa_q.size() + exp_out_q.size() != 0) begin
                miscompares++;
                $display("[TB] FAIL leftover: got %0d/%0d/%0d pending rd/wr/out expected 0", exp_rd_q.size(), exp_wa_q.size(), exp_out_q.size());
            end
            @(negedge clk);
            vectors++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL post_done: got done=%b busy=%b expected 0 0", done, busy);
            end
            bad = 0;
            for (int i = 0; i < 64; i++) if (mem[i] !== exp_img[i]) bad++;
            vectors++;
            if (bad != 0) begin
                miscompares++;
                $display("[TB] FAIL ram_image: got %0d words differing expected 0", bad);
            end
        end
    endtask

    task automatic test_reset();
        vectors++;
        if ({busy, done, out_valid, in_ready, m_chipselect, m_write} !== 6'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_ctrl: got %b expected 000000", {busy, done, out_valid, in_ready, m_chipselect, m_write});
        end
        vectors++;
        if (m_address !== 6'd0 || m_writedata !== '0 || out_data !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_data: got addr %0d wd %h od %h expected 0", m_address, m_writedata, out_data);
        end
        vectors++;
        if (m_byteenable !== 32'hFFFF_FFFF || m_clken !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL constants: got be %h clken %b expected ffffffff 1", m_byteenable, m_clken);
        end
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL idle_busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_single_word();
        bit ab;
        load_word(5, {32{8'hA5}});
        drive_sweep(5, 1, 0, 0, 0, 1'b0, -1, -1, 7, ab);
        vectors++;
        if (mem[5] !== {32{8'h5A}}) begin
            miscompares++;
            $display("[TB] FAIL single_word_ram: got %h expected %h", mem[5], {32{8'h5A}});
        end
    endtask

    task automatic test_wrap();
        bit ab;
        drive_sweep(62, 4, 0, 0, 0, 1'b0, -1, -1, 25, ab);
    endtask

    task automatic test_backpressure();
        bit ab;
        drive_sweep(20, 3, 1, 10, 7, 1'b1, -1, -1, 70, ab);
    endtask

    task automatic test_count_zero();
        bit ab;
        drive_sweep(7, 0, 0, 0, 0, 1'b0, -1, -1, 1, ab);
    endtask

    task automatic test_start_while_busy();
        bit ab;
        drive_sweep(40, 3, 1, 0, 0, 1'b0, 3, -1, 19, ab);
    endtask

    task automatic test_reset_mid_sweep();
        bit ab;
        drive_sweep(10, 8, 1, 0, 0, 1'b0, -1, 2, -1, ab);
        vectors++;
        if (!ab) begin
            miscompares++;
            $display("[TB] FAIL abort_point: got not reached expected IN of word 3");
        end
        reset = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        vectors++;
        if ({busy, done, out_valid, in_ready, m_chipselect, m_write} !== 6'b0) begin
            miscompares++;
            $display("[TB] FAIL midreset_ctrl: got %b expected 000000", {busy, done, out_valid, in_ready, m_chipselect, m_write});
        end
        vectors++;
        if (m_address !== 6'd0 || m_writedata !== '0 || out_data !== '0) begin
            miscompares++;
            $display("[TB] FAIL midreset_data: got addr %0d wd %h od %h expected 0", m_address, m_writedata, out_data);
        end
        vectors++;
        if (mem[12] !== exp_img[12]) begin
            miscompares++;
            $display("[TB] FAIL word3_written: got %h expected %h", mem[12], exp_img[12]);
        end
        reset = 1'b0;
        @(negedge clk);
        drive_sweep(10, 8, 1, 0, 0, 1'b0, -1, -1, 49, ab);
    endtask

    task automatic test_full_sweep();
        bit ab;
        drive_sweep(0, 64, 1, 0, 0, 1'b0, -1, -1, 6 * 64 + 1, ab);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; base_addr = '0; word_count = '0;
        out_ready = 1'b0; in_valid = 1'b0; in_data = '0;
        load_en = 1'b0; load_addr = '0; load_data = '0;
        repeat (3) @(negedge clk);
        test_reset();
        for (int i = 0; i < 64; i++)
            load_word(i, {$urandom(), $urandom(), $urandom(), $urandom(),
                          $urandom(), $urandom(), $urandom(), $urandom()});
        test_single_word();
        test_wrap();
        test_backpressure();
        test_count_zero();
        test_start_while_busy();
        test_reset_mid_sweep();
        test_full_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
